// File: rtl/muldiv_seq.sv
// Radix-2 sequential RV32M multiply/divide unit: one shift-add or shift-subtract step per cycle.
// Operands are reduced to magnitudes on accept; the sign fix-up is applied on the DONE entry edge.
module muldiv_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    input  logic [DATA_WIDTH-1:0] srca_i,
    input  logic [DATA_WIDTH-1:0] srcb_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     count;
    logic [OP_WIDTH-1:0] op;
    logic [2*W-1:0]    acc;
    logic [W-1:0]      opnd;
    logic              neg_main;
    logic              neg_rem;
    logic [W-1:0]      result;

    logic              accept;
    logic              is_div;
    logic              div_zero;
    logic              signed_a;
    logic              signed_b;
    logic              neg_a;
    logic              neg_b;
    logic [W-1:0]      mag_a;
    logic [W-1:0]      mag_b;

    logic [W:0]        mul_sum;
    logic [W:0]        div_trial;
    logic [W-1:0]      quot_shift;
    logic [2*W-1:0]    acc_step;
    logic [2*W-1:0]    prod_fix;
    logic [W-1:0]      quot_fix;
    logic [W-1:0]      rem_fix;
    logic [W-1:0]      result_fix;

    // Request decode and operand magnitude extraction
    always_comb begin
        accept   = start_i && (state == S_IDLE) && !flush_i;
        is_div   = op_i[2];
        div_zero = is_div && (srcb_i == '0);
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (op_i[2:0])
            3'b001, 3'b100, 3'b110: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            3'b010:  signed_a = 1'b1;
            default: ;
        endcase
        neg_a = signed_a && srca_i[W-1];
        neg_b = signed_b && srcb_i[W-1];
        mag_a = neg_a ? (~srca_i + 1'b1) : srca_i;
        mag_b = neg_b ? (~srcb_i + 1'b1) : srcb_i;
    end

    // One iteration: acc holds {product high, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum    = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
        div_trial  = acc[2*W-1:W-1] - {1'b0, opnd};
        quot_shift = {acc[W-2:0], 1'b0};
        acc_step   = acc;
        if (op[2]) begin
            if (!div_trial[W])
                acc_step = {div_trial[W-1:0], quot_shift | {{(W-1){1'b0}}, 1'b1}};
            else
                acc_step = {acc[2*W-2:W-1], quot_shift};
        end else begin
            if (acc[0])
                acc_step = {mul_sum, acc[W-1:1]};
            else
                acc_step = {1'b0, acc[2*W-1:1]};
        end
    end

    // Sign fix-up and result selection on the final iteration's output
    always_comb begin
        prod_fix = neg_main ? (~acc_step + 1'b1) : acc_step;
        quot_fix = neg_main ? (~acc_step[W-1:0] + 1'b1) : acc_step[W-1:0];
        rem_fix  = neg_rem ? (~acc_step[2*W-1:W] + 1'b1) : acc_step[2*W-1:W];
        if (op[2])
            result_fix = op[1] ? rem_fix : quot_fix;
        else if (op[1:0] == 2'b00)
            result_fix = prod_fix[W-1:0];
        else
            result_fix = prod_fix[2*W-1:W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_next = div_zero ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                if (flush_i)
                    state_next = S_IDLE;
                else if (count == CW'(1))
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (flush_i || result_ready_i)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o        = (state == S_IDLE);
        busy_o         = (state == S_BUSY);
        result_valid_o = (state == S_DONE);
    end

    assign result_o = result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            op       <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op       <= op_i;
                        count    <= CW'(DATA_WIDTH);
                        neg_main <= neg_a ^ neg_b;
                        neg_rem  <= neg_a;
                        if (is_div) begin
                            acc  <= {{W{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{W{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                        if (div_zero)
                            result <= op_i[1] ? srca_i : '1;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        count <= '0;
                    end else begin
                        acc   <= acc_step;
                        count <= count - 1'b1;
                        if (count == CW'(1))
                            result <= result_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboarded bench for muldiv_seq: driver pushes reference results, monitor pops on each DONE.
module tb_muldiv_seq;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        rready = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] result_o;

    muldiv_seq #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .srca_i(a), .srcb_i(b),
        .flush_i(flush), .ready_o(ready_o), .busy_o(busy_o), .result_valid_o(result_valid_o),
        .result_ready_i(rready), .result_o(result_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t q[$];
    bit   hold_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the RISC-V definitions
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        longint r  = 0;
        case (o)
            3'd0: r = sx * sy;
            3'd1: r = (sx * sy) >>> 32;
            3'd2: r = (sx * uy) >>> 32;
            3'd3: r = (ux * uy) >> 32;
            3'd4: r = (y == 0) ? -1 : sx / sy;
            3'd5: r = (y == 0) ? -1 : ux / uy;
            3'd6: r = (y == 0) ? sx : sx % sy;
            default: r = (y == 0) ? ux : ux % uy;
        endcase
        return r[31:0];
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready_o && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!ready_o) check("ready_wait", {31'b0, ready_o}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit junk);
        exp_t e;
        wait_ready();
        op = o; a = x; b = y; start = 1'b1;
        e.res = model(o, x, y);
        e.lat = (o[2] && y == 32'd0) ? 0 : W;
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        q.push_back(e);
        @(negedge clk);
        if (e.lat != 0) begin
            check("busy_in_busy", {31'b0, busy_o}, 32'd1);
            check("ready_in_busy", {31'b0, ready_o}, 32'd0);
            if (junk) begin
                repeat (3) begin
                    op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
                    @(negedge clk);
                end
            end
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
        check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_valid"}, {31'b0, result_valid_o}, 32'd0);
        check({tag, "_result"}, result_o, 32'd0);
    endtask

    // Monitor: compares each fresh DONE against the queue head and polices DONE stability
    initial begin
        exp_t cur;
        bit prev_valid = 1'b0;
        bit prev_rready = 1'b0;
        bit force_rel = 1'b0;
        int hold = 0;
        cur.res = '0; cur.acc_cyc = 0; cur.lat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                rready = 1'b0;
                continue;
            end
            if (result_valid_o) begin
                if (prev_valid && prev_rready)
                    check("exit_on_ready", {31'b0, result_valid_o}, 32'd0);
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid: got result %h want no result", result_o);
                    end else begin
                        cur = q.pop_front();
                        check("result", result_o, cur.res);
                        check("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
                        if (hold_req) begin
                            hold = 10;
                            hold_req = 1'b0;
                        end
                    end
                end else begin
                    check("result_stable", result_o, cur.res);
                    check("ready_in_done", {31'b0, ready_o}, 32'd0);
                end
                if (hold > 0) begin
                    rready = 1'b0;
                    hold--;
                    if (hold == 0) force_rel = 1'b1;
                end else if (force_rel) begin
                    rready = 1'b1;
                    force_rel = 1'b0;
                end else begin
                    rready = ($urandom_range(0, 3) != 0);
                end
            end else begin
                rready = 1'($urandom_range(0, 1));
            end
            prev_valid = result_valid_o;
            prev_rready = rready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        issue(3'd0, 32'd7, 32'd6, 1'b0);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(3'd5, 32'd100, 32'd7, 1'b0);
        issue(3'd7, 32'd100, 32'd7, 1'b0);
        issue(3'd5, 32'd5, 32'd0, 1'b0);
        issue(3'd7, 32'd5, 32'd0, 1'b0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        hold_req = 1'b1;
        issue(3'd3, 32'd123, 32'd456, 1'b0);

        // Flush in BUSY cycle 5: back to IDLE, no result
        wait_ready();
        op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_idle", {31'b0, ready_o}, 32'd1);

        // Flush in IDLE blocks the accept
        op = 3'd5; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_idle_noaccept", {31'b0, ready_o}, 32'd1);

        // Asynchronous reset in the middle of BUSY
        wait_ready();
        op = 3'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++)
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));

        n = 0;
        while (q.size() != 0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
